// File: rtl/inv_trans_mat.sv
// Inverse rigid transform p = R^T * (q - t): five-stage pipeline, one point per cycle.
// Pose updates land in a pending buffer and are committed only after the pipeline drains.
module inv_trans_mat #(
  parameter int unsigned CLOUD_BW = 42,
  parameter int unsigned POSE_BW  = 42,
  parameter int unsigned MUL      = 28
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic [CLOUD_BW-1:0]   i_cloud_x,
  input  logic [CLOUD_BW-1:0]   i_cloud_y,
  input  logic [CLOUD_BW-1:0]   i_cloud_z,
  input  logic                  i_pose_load,
  input  logic [12*POSE_BW-1:0] i_pose,
  output logic                  o_ready,
  output logic                  o_drop,
  output logic                  o_valid,
  output logic [CLOUD_BW-1:0]   o_cloud_x,
  output logic [CLOUD_BW-1:0]   o_cloud_y,
  output logic [CLOUD_BW-1:0]   o_cloud_z
);

  localparam int unsigned DW  = CLOUD_BW + 1;
  localparam int unsigned PW  = DW + POSE_BW;
  localparam int unsigned MW  = PW - MUL;
  localparam int unsigned S1W = MW + 1;
  localparam int unsigned S2W = MW + 2;
  localparam logic signed [POSE_BW-1:0] POSE_ONE = POSE_BW'(1) << MUL;

  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_COMMIT} state_e;

  state_e state_q, state_d;

  logic signed [POSE_BW-1:0] pose_q [12];
  logic signed [POSE_BW-1:0] pose_d [12];
  logic signed [POSE_BW-1:0] pend_q [12];
  logic signed [POSE_BW-1:0] pend_d [12];
  logic                      ready_q, ready_d;
  logic                      drop_q, drop_d;
  logic [4:0]                vld_q, vld_d;
  logic                      accept_c;

  logic signed [CLOUD_BW-1:0] q_c     [3];
  logic signed [DW-1:0]       diff_q  [3];
  logic signed [DW-1:0]       diff_d  [3];
  logic signed [PW-1:0]       prod1_q [9];
  logic signed [PW-1:0]       prod1_d [9];
  logic signed [PW-1:0]       prod2_q [9];
  logic signed [S1W-1:0]      sum01_q [3];
  logic signed [S1W-1:0]      sum01_d [3];
  logic signed [MW-1:0]       m2_q    [3];
  logic signed [MW-1:0]       m2_d    [3];
  logic [CLOUD_BW-1:0]        out_q   [3];
  logic [CLOUD_BW-1:0]        out_d   [3];

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_ACTIVE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: DRAIN waits for an empty valid pipe before COMMIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACTIVE: if (i_pose_load) state_d = ST_DRAIN;
      ST_DRAIN:  if (vld_q == 5'd0) state_d = ST_COMMIT;
      ST_COMMIT: state_d = i_pose_load ? ST_DRAIN : ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  // FSM outputs: handshake, valid pipe and pose buffers
  always_comb begin
    accept_c = i_valid & ready_q;
    vld_d    = {vld_q[3:0], accept_c};
    drop_d   = i_valid & ~ready_q;
    ready_d  = (state_d == ST_ACTIVE);
    pend_d   = pend_q;
    pose_d   = pose_q;
    if (i_pose_load) begin
      for (int k = 0; k < 12; k++) pend_d[k] = i_pose[k*POSE_BW +: POSE_BW];
    end
    if (state_q == ST_COMMIT) pose_d = pend_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q <= 1'b1;
      drop_q  <= 1'b0;
      vld_q   <= 5'd0;
      // indices 0, 5 and 10 are the rotation diagonal
      for (int k = 0; k < 12; k++) begin
        pose_q[k] <= (k % 5 == 0) ? POSE_ONE : '0;
        pend_q[k] <= '0;
      end
    end else begin
      ready_q <= ready_d;
      drop_q  <= drop_d;
      vld_q   <= vld_d;
      pose_q  <= pose_d;
      pend_q  <= pend_d;
    end
  end

  // Datapath: translate, transpose-multiply, floor-scale, two-level add
  always_comb begin
    q_c[0] = $signed(i_cloud_x);
    q_c[1] = $signed(i_cloud_y);
    q_c[2] = $signed(i_cloud_z);
    for (int k = 0; k < 3; k++) begin
      diff_d[k] = DW'(q_c[k]) - DW'(pose_q[4*k+3]);
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        prod1_d[3*i+j] = PW'(diff_q[j]) * PW'(pose_q[4*j+i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      sum01_d[i] = S1W'(prod2_q[3*i] >>> MUL) + S1W'(prod2_q[3*i+1] >>> MUL);
      m2_d[i]    = MW'(prod2_q[3*i+2] >>> MUL);
      out_d[i]   = CLOUD_BW'(S2W'(sum01_q[i]) + S2W'(m2_q[i]));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 3; k++) begin
        diff_q[k]  <= '0;
        sum01_q[k] <= '0;
        m2_q[k]    <= '0;
        out_q[k]   <= '0;
      end
      for (int k = 0; k < 9; k++) begin
        prod1_q[k] <= '0;
        prod2_q[k] <= '0;
      end
    end else begin
      diff_q  <= diff_d;
      prod1_q <= prod1_d;
      prod2_q <= prod1_q;
      sum01_q <= sum01_d;
      m2_q    <= m2_d;
      out_q   <= out_d;
    end
  end

  assign o_ready   = ready_q;
  assign o_drop    = drop_q;
  assign o_valid   = vld_q[4];
  assign o_cloud_x = out_q[0];
  assign o_cloud_y = out_q[1];
  assign o_cloud_z = out_q[2];

endmodule

// File: tb/tb_inv_trans_mat.sv
// Directed bench for inv_trans_mat: a timeline model of the pose handshake plus
// wide-integer math for R^T(q - t), checked against the DUT every cycle.
module tb_inv_trans_mat;

  localparam int unsigned CW = 42;
  localparam int unsigned PB = 42;
  localparam int unsigned FR = 28;

  typedef logic signed [CW-1:0] el_t;
  typedef struct {
    int  due;
    el_t x;
    el_t y;
    el_t z;
  } exp_t;

  logic              clk, rst_n, vin, ld;
  el_t               qx, qy, qz;
  logic [12*PB-1:0]  pose_flat;
  logic              o_ready, o_drop, o_valid;
  logic [CW-1:0]     ox, oy, oz;

  inv_trans_mat #(.CLOUD_BW(CW), .POSE_BW(PB), .MUL(FR)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin),
    .i_cloud_x(qx), .i_cloud_y(qy), .i_cloud_z(qz),
    .i_pose_load(ld), .i_pose(pose_flat),
    .o_ready(o_ready), .o_drop(o_drop), .o_valid(o_valid),
    .o_cloud_x(ox), .o_cloud_y(oy), .o_cloud_z(oz)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int   n_cmp = 0;
  int   n_err = 0;
  bit   exp_ready, exp_valid, exp_drop;
  el_t  exp_p [3];
  bit   busy;
  int   load_e, last_acc, ecnt;
  el_t  act [12];
  el_t  pend [12];
  exp_t exp_q [$];
  el_t  rt_q [$];
  bit   smp_ready, smp_drop, smp_valid;
  el_t  last_p [3];

  function automatic el_t fx(input int v);
    return CW'(longint'(v) <<< FR);
  endfunction

  function automatic el_t rnd();
    return CW'(longint'($signed($urandom)) <<< 7);
  endfunction

  function automatic logic [12*PB-1:0] pack(input el_t r [12]);
    logic [12*PB-1:0] f;
    f = '0;
    for (int k = 0; k < 12; k++) f[k*PB +: PB] = r[k];
    return f;
  endfunction

  task automatic unpack(input logic [12*PB-1:0] f, output el_t r [12]);
    for (int k = 0; k < 12; k++) r[k] = f[k*PB +: PB];
  endtask

  task automatic ident(output el_t r [12]);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 4; j++) r[i*4+j] = (i == j) ? fx(1) : '0;
  endtask

  // p_i = sum_j floor(R[j][i] * (q_j - t_j) / 2^FR), wrapped to CW bits
  task automatic model_p(input el_t q [3], input el_t r [12], output el_t p [3]);
    logic signed [127:0] d, acc;
    for (int i = 0; i < 3; i++) begin
      acc = '0;
      for (int j = 0; j < 3; j++) begin
        d   = 128'(q[j]) - 128'(r[j*4+3]);
        acc = acc + ((d * 128'(r[j*4+i])) >>> FR);
      end
      p[i] = CW'(acc);
    end
  endtask

  // forward pose: q'_i = sum_j floor(R[i][j] * q_j / 2^FR) + t_i
  task automatic fwd(input el_t q [3], input el_t r [12], output el_t o [3]);
    logic signed [127:0] acc;
    for (int i = 0; i < 3; i++) begin
      acc = 128'(r[i*4+3]);
      for (int j = 0; j < 3; j++) acc = acc + ((128'(r[i*4+j]) * 128'(q[j])) >>> FR);
      o[i] = CW'(acc);
    end
  endtask

  task automatic rand_pose(output el_t r [12]);
    int perm [3];
    int a, b, tmp;
    perm = '{0, 1, 2};
    a = $urandom_range(0, 2);
    b = $urandom_range(0, 2);
    tmp = perm[a]; perm[a] = perm[b]; perm[b] = tmp;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++)
        r[i*4+j] = (j == perm[i]) ? (($urandom_range(0, 1) == 1) ? -fx(1) : fx(1)) : '0;
      r[i*4+3] = rnd();
    end
  endtask

  task automatic mdl_reset();
    busy = 0; load_e = 0; last_acc = -100; ecnt = 0;
    exp_ready = 1; exp_valid = 0; exp_drop = 0;
    exp_p = '{'0, '0, '0};
    ident(act);
    for (int k = 0; k < 12; k++) pend[k] = '0;
    exp_q.delete();
  endtask

  // Reference timeline: pose commits two edges after the pipe is empty past the load
  initial begin : model
    el_t  qv [3];
    el_t  pv [3];
    exp_t e;
    int   commit_e;
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mdl_reset();
      end else begin
        ecnt++;
        exp_valid = 0;
        if (exp_q.size() > 0 && exp_q[0].due == ecnt) begin
          e = exp_q.pop_front();
          exp_valid = 1;
          exp_p = '{e.x, e.y, e.z};
        end
        if (vin && !busy) begin
          qv = '{qx, qy, qz};
          model_p(qv, act, pv);
          e.due = ecnt + 4; e.x = pv[0]; e.y = pv[1]; e.z = pv[2];
          exp_q.push_back(e);
          last_acc = ecnt;
        end
        exp_drop = vin && busy;
        commit_e = ((load_e > last_acc + 5) ? load_e : last_acc + 5) + 2;
        if (busy && ecnt == commit_e) begin
          act = pend;
          if (ld) begin
            unpack(pose_flat, pend);
            load_e = ecnt;
          end else begin
            busy = 0;
          end
        end else if (ld) begin
          unpack(pose_flat, pend);
          if (!busy) begin
            busy = 1;
            load_e = ecnt;
          end
        end
        exp_ready = !busy;
      end
    end
  end

  task automatic chk1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk42(input string name, input el_t got, input el_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic chk_rt(input string name, input el_t got, input el_t want);
    longint diff;
    diff = longint'(got) - longint'(want);
    n_cmp++;
    if (diff > 2 || diff < -2) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d +-2", name, got, want);
    end
  endtask

  task automatic check_outputs();
    el_t o [3];
    chk1("o_ready", o_ready, exp_ready);
    chk1("o_valid", o_valid, exp_valid);
    chk1("o_drop", o_drop, exp_drop);
    if (exp_valid) begin
      chk42("o_cloud_x", $signed(ox), exp_p[0]);
      chk42("o_cloud_y", $signed(oy), exp_p[1]);
      chk42("o_cloud_z", $signed(oz), exp_p[2]);
    end
    smp_ready = o_ready;
    smp_drop  = o_drop;
    smp_valid = o_valid;
    if (o_valid) begin
      o = '{$signed(ox), $signed(oy), $signed(oz)};
      last_p = o;
      if (rt_q.size() >= 3) begin
        for (int k = 0; k < 3; k++) chk_rt("round_trip", o[k], rt_q.pop_front());
      end
    end
  endtask

  task automatic step(input bit v, input el_t x, input el_t y, input el_t z,
                      input bit l, input logic [12*PB-1:0] p);
    @(negedge clk);
    if (rst_n) check_outputs();
    vin = v; qx = x; qy = y; qz = z; ld = l; pose_flat = p;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, '0, 0, pose_flat);
  endtask

  task automatic send(input el_t x, input el_t y, input el_t z);
    step(1, x, y, z, 0, pose_flat);
  endtask

  task automatic load(input el_t r [12]);
    step(0, '0, '0, '0, 1, pack(r));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; vin = 0; ld = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  initial begin : main
    el_t pi [12];
    el_t pt [12];
    el_t pz [12];
    el_t pr [12];
    el_t pa [12];
    el_t qv [3];
    el_t pv [3];
    int  nlow, ndrop;

    rst_n = 0; vin = 0; ld = 0; qx = '0; qy = '0; qz = '0; pose_flat = '0;

    ident(pi);
    pt = pi; pt[3] = fx(1); pt[7] = fx(2); pt[11] = fx(3);
    pz = '{'0, -fx(1), '0, '0, fx(1), '0, '0, '0, '0, '0, fx(1), '0};

    // model pins from hand-worked cases
    qv = '{fx(5), fx(-3), fx(7)};
    model_p(qv, pi, pv);
    chk42("pin_id_x", pv[0], fx(5)); chk42("pin_id_y", pv[1], fx(-3)); chk42("pin_id_z", pv[2], fx(7));
    qv = '{fx(4), fx(4), fx(4)};
    model_p(qv, pt, pv);
    chk42("pin_tr_x", pv[0], fx(3)); chk42("pin_tr_y", pv[1], fx(2)); chk42("pin_tr_z", pv[2], fx(1));
    qv = '{fx(1), '0, '0};
    model_p(qv, pz, pv);
    chk42("pin_rz_x", pv[0], '0); chk42("pin_rz_y", pv[1], fx(-1)); chk42("pin_rz_z", pv[2], '0);

    repeat (3) @(negedge clk);
    rst_n = 1;
    idle(1);
    chk1("reset_ready", smp_ready, 1'b1);
    chk1("reset_valid", smp_valid, 1'b0);
    chk1("reset_drop", smp_drop, 1'b0);

    // identity after reset, 5-cycle latency
    send(fx(5), fx(-3), fx(7));
    for (int k = 1; k <= 6; k++) begin
      idle(1);
      chk1("latency_valid", smp_valid, k == 5);
    end
    chk42("id_x", last_p[0], fx(5)); chk42("id_y", last_p[1], fx(-3)); chk42("id_z", last_p[2], fx(7));

    // translation, including a wrap at the negative limit
    load(pt);
    idle(9);
    send(fx(4), fx(4), fx(4));
    send(42'sh200_0000_0000, '0, '0);
    idle(7);
    chk42("wrap_x", last_p[0], 42'sh1FF_F000_0000);
    chk42("wrap_y", last_p[1], fx(-2));
    chk42("wrap_z", last_p[2], fx(-3));

    // 90 degree yaw
    load(pz);
    idle(9);
    send(fx(1), '0, '0);
    idle(7);
    chk42("rz_x", last_p[0], '0); chk42("rz_y", last_p[1], fx(-1)); chk42("rz_z", last_p[2], '0);

    // mid-stream update, second load while draining
    pa = pz; pa[3] = rnd(); pa[7] = rnd(); pa[11] = rnd();
    rand_pose(pr);
    nlow = 0; ndrop = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, rnd(), rnd(), rnd(), (i == 5) || (i == 8), (i == 5) ? pack(pa) : pack(pr));
      if (!smp_ready) nlow++;
      if (smp_drop) ndrop++;
    end
    idle(8);
    chk_int("ready_low_cycles", nlow, 7);
    chk_int("drop_pulses", ndrop, 7);

    // second load lands exactly on the commit cycle
    nlow = 0;
    for (int i = 0; i < 16; i++) begin
      step(1, rnd(), rnd(), rnd(), (i == 2) || (i == 9), (i == 2) ? pack(pa) : pack(pz));
      if (!smp_ready) nlow++;
    end
    idle(8);
    chk_int("ready_low_recommit", nlow, 9);

    // round trip through random exact poses
    for (int p = 0; p < 3; p++) begin
      rand_pose(pr);
      load(pr);
      idle(9);
      for (int n = 0; n < 6; n++) begin
        qv = '{rnd(), rnd(), rnd()};
        fwd(qv, pr, pv);
        for (int k = 0; k < 3; k++) rt_q.push_back(qv[k]);
        send(pv[0], pv[1], pv[2]);
      end
      idle(7);
    end
    chk_int("rt_leftover", rt_q.size(), 0);

    // reset mid-stream with a load pending
    load(pa);
    for (int i = 0; i < 3; i++) send(rnd(), rnd(), rnd());
    do_reset();
    idle(1);
    chk1("rst_ready", smp_ready, 1'b1);
    idle(8);
    qv = '{rnd(), rnd(), rnd()};
    send(qv[0], qv[1], qv[2]);
    idle(7);
    chk42("rst_id_x", last_p[0], qv[0]);
    chk42("rst_id_y", last_p[1], qv[1]);
    chk42("rst_id_z", last_p[2], qv[2]);
    chk_int("exp_leftover", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
